// File: rtl/fbuf_arbiter.sv
// rtl/fbuf_arbiter.sv - two-port framebuffer RAM arbiter with lock, preemption and read tagging.
// Optional FBUF_ARB_FAIR_EN: alternating tie-break and MAX_HOLD preemption of unlocked owners.
module fbuf_arbiter #(
    parameter int AW       = 9,
    parameter int DW       = 16,
    parameter int MAX_HOLD = 16
) (
    input  logic          clk,
    input  logic          res,
    input  logic          rq0_req,
    input  logic          rq0_write,
    input  logic          rq0_lock,
    input  logic [AW-1:0] rq0_addr,
    input  logic [DW-1:0] rq0_wdata,
    input  logic          rq1_req,
    input  logic          rq1_write,
    input  logic          rq1_lock,
    input  logic [AW-1:0] rq1_addr,
    input  logic [DW-1:0] rq1_wdata,
    output logic          rq0_ack,
    output logic          rq0_rvalid,
    output logic          rq0_grant,
    output logic          rq1_ack,
    output logic          rq1_rvalid,
    output logic          rq1_grant,
    output logic [DW-1:0] rdata,
    output logic          fb_en,
    output logic          fb_write,
    output logic [AW-1:0] fb_addr,
    output logic [DW-1:0] fb_wdata,
    input  logic [DW-1:0] fb_rdata
);
    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [1:0] r_rvpipe;
    logic       w_own0;
    logic       w_own1;
    logic       w_pre0;
    logic       w_pre1;
    logic       w_rel0;
    logic       w_rel1;
    logic       w_tie0;

    // Reset blanks every output at once so an in-flight read never surfaces.
    assign w_own0     = (r_state == OWN0) && !res;
    assign w_own1     = (r_state == OWN1) && !res;
    assign rq0_grant  = w_own0;
    assign rq1_grant  = w_own1;
    assign rq0_ack    = w_own0 && rq0_req;
    assign rq1_ack    = w_own1 && rq1_req;
    assign fb_en      = rq0_ack || rq1_ack;
    assign rq0_rvalid = r_rvpipe[0] && !res;
    assign rq1_rvalid = r_rvpipe[1] && !res;
    assign rdata      = (rq0_rvalid || rq1_rvalid) ? fb_rdata : '0;

    always_comb begin
        fb_write = 1'b0;
        fb_addr  = '0;
        fb_wdata = '0;
        if (w_own0) begin
            fb_write = rq0_write;
            fb_addr  = rq0_addr;
            fb_wdata = rq0_wdata;
        end else if (w_own1) begin
            fb_write = rq1_write;
            fb_addr  = rq1_addr;
            fb_wdata = rq1_wdata;
        end
    end

`ifdef FBUF_ARB_FAIR_EN
    logic [7:0] r_hold_cnt;
    logic [7:0] w_hold_nxt;
    logic       r_last_owner;

    // Preemption looks at the count including this cycle's ack, so the owner gets exactly MAX_HOLD accesses.
    assign w_hold_nxt = (fb_en && r_hold_cnt != 8'(MAX_HOLD)) ? r_hold_cnt + 8'd1 : r_hold_cnt;
    assign w_pre0     = w_own0 && (w_hold_nxt == 8'(MAX_HOLD)) && !rq0_lock && rq1_req;
    assign w_pre1     = w_own1 && (w_hold_nxt == 8'(MAX_HOLD)) && !rq1_lock && rq0_req;
    assign w_tie0     = r_last_owner;

    always_ff @(posedge clk) begin
        if (res) begin
            r_hold_cnt   <= 8'd0;
            r_last_owner <= 1'b1;
        end else begin
            r_hold_cnt <= (w_state_nxt != r_state) ? 8'd0 : w_hold_nxt;
            if (r_state == OWN0 && w_rel0) begin
                r_last_owner <= 1'b0;
            end else if (r_state == OWN1 && w_rel1) begin
                r_last_owner <= 1'b1;
            end
        end
    end
`else
    logic w_unused_cfg;

    assign w_unused_cfg = (MAX_HOLD > 255);
    assign w_pre0       = 1'b0;
    assign w_pre1       = 1'b0;
    assign w_tie0       = 1'b1;
`endif

    assign w_rel0 = (!rq0_req && !rq0_lock) || w_pre0;
    assign w_rel1 = (!rq1_req && !rq1_lock) || w_pre1;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (rq0_req && (!rq1_req || w_tie0)) begin
                    w_state_nxt = OWN0;
                end else if (rq1_req) begin
                    w_state_nxt = OWN1;
                end
            end
            OWN0: begin
                if (w_rel0) begin
                    w_state_nxt = rq1_req ? OWN1 : IDLE;
                end
            end
            OWN1: begin
                if (w_rel1) begin
                    w_state_nxt = rq0_req ? OWN0 : IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (res) begin
            r_state  <= IDLE;
            r_rvpipe <= 2'b00;
        end else begin
            r_state  <= w_state_nxt;
            r_rvpipe <= {rq1_ack && !rq1_write, rq0_ack && !rq0_write};
        end
    end
endmodule
